// File: rtl/hub75_spi_streamer.sv
// SPI master streaming one frame of pixel words to the HUB75 panel controller's SPI input.
// Mode 0, MSB first, no chip-select needed by the slave; spi_cs_n only marks the frame envelope.
module hub75_spi_streamer #(
    parameter int CLK_DIV         = 2,
    parameter int WORDS_PER_FRAME = 2048,
    parameter int WORD_BITS       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] pixel_data,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 spi_cs_n,
    input  logic                 spi_miso,
    output logic [2:0]           fsm_state
);

    localparam int WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int BCW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int DCW = $clog2(CLK_DIV) + 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_BITS - 1);
    localparam logic [DCW-1:0] DIV_TERM  = DCW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        SHIFT_LOW  = 3'd2,
        SHIFT_HIGH = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t               state;
    logic [WCW-1:0]       word_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DCW-1:0]       div_cnt;
    // The MSB goes straight to spi_mosi on load, so only the remaining bits are held here.
    logic [WORD_BITS-2:0] shreg;

    // MISO is not part of this link; the panel controller ties it low.
    logic unused_miso;
    assign unused_miso = spi_miso;

    // Handshake: a word transfers on a rising clk edge where pixel_valid && pixel_ready.
    // pixel_ready depends only on state, never on pixel_valid; the source may hold
    // pixel_valid low for any time (underrun simply stretches the frame).
    assign pixel_ready = (state == LOAD);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= '0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        word_cnt <= '0;
                    end
                end
                LOAD: begin
                    spi_clk <= 1'b0;
                    if (pixel_valid) begin
                        shreg    <= pixel_data[WORD_BITS-2:0];
                        spi_mosi <= pixel_data[WORD_BITS-1];
                        bit_cnt  <= LAST_BIT;
                        div_cnt  <= '0;
                        state    <= SHIFT_LOW;
                    end
                end
                SHIFT_LOW: begin
                    if (div_cnt == DIV_TERM) begin
                        spi_clk <= 1'b1;
                        div_cnt <= '0;
                        state   <= SHIFT_HIGH;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                SHIFT_HIGH: begin
                    if (div_cnt == DIV_TERM) begin
                        // MOSI only moves together with the falling edge, giving a full low phase of setup.
                        spi_clk <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt != '0) begin
                            spi_mosi <= shreg[WORD_BITS-2];
                            shreg    <= {shreg[WORD_BITS-3:0], 1'b0};
                            bit_cnt  <= bit_cnt - BCW'(1);
                            state    <= SHIFT_LOW;
                        end else if (word_cnt == LAST_WORD) begin
                            state <= DONE;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                            state    <= LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    spi_cs_n   <= 1'b1;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    spi_mosi   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_spi_streamer.sv
// Directed bench for hub75_spi_streamer: SPI slave model, expected-word queue, frame timing checks.
module tb_hub75_spi_streamer;

    localparam int NW  = 12;
    localparam int DIV = 2;
    localparam int FRAME_CYCLES = NW * (1 + 2 * DIV * 16) + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        busy;
    logic        frame_done;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso = 1'b0;
    logic [2:0]  fsm_state;

    hub75_spi_streamer #(
        .CLK_DIV(DIV),
        .WORDS_PER_FRAME(NW),
        .WORD_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .busy(busy),
        .frame_done(frame_done),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [15:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          rx_bits = 0;
    logic [15:0] rx = '0;
    logic        prev_clk = 1'b0;
    logic        prev_mosi = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] first, input logic [15:0] base, input int i);
        return (i == 0) ? first : base + 16'(i);
    endfunction

    // One clock: sample on the falling edge and run the SPI slave model.
    task automatic tick();
        logic [31:0] exp_w;
        @(negedge clk);
        if (frame_done) done_cnt++;
        if (reset) begin
            rx_bits = 0;
        end else begin
            if (spi_clk && !prev_clk) begin
                rise_cnt++;
                check("cs_envelope", 32'(spi_cs_n), 0);
                rx = {rx[14:0], spi_mosi};
                rx_bits++;
                if (rx_bits == 16) begin
                    rx_bits = 0;
                    exp_w = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_0000;
                    check("rx_word", 32'(rx), exp_w);
                end
            end
            if (spi_mosi !== prev_mosi) check("mosi_while_low", 32'(spi_clk), 0);
        end
        prev_clk  = spi_clk;
        prev_mosi = spi_mosi;
    endtask

    // driver: one frame request plus the pixel source behind it
    task automatic run_frame(input logic [15:0] first, input logic [15:0] base, input int stall_len,
                             input bit poke, input int abort_rise, input int exp_period);
        int          word_idx = 0;
        int          stall_cnt = 0;
        int          done_at = -1;
        int          last_acc = -1;
        int          rise0 = rise_cnt;
        int          done0 = done_cnt;
        bit          aborted = 1'b0;
        logic [15:0] w;
        logic [15:0] w2;
        w2 = word_of(first, base, 2);
        start = 1'b1;
        pixel_valid = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            tick();
            start = 1'b0;
            if (c == 1) check("busy_rise", 32'({busy, spi_cs_n}), 2);
            if (frame_done) begin
                done_at = c;
                break;
            end
            if (abort_rise >= 0 && (rise_cnt - rise0) == abort_rise) begin
                reset = 1'b1;
                pixel_valid = 1'b0;
                tick();
                reset = 1'b0;
                check("abort_outputs", 32'({spi_clk, spi_cs_n, busy, frame_done, pixel_ready}), 5'b01000);
                aborted = 1'b1;
                break;
            end
            if (poke && c == 300) start = 1'b1;
            pixel_valid = 1'b0;
            if (pixel_ready && word_idx < NW) begin
                if (word_idx == 3 && stall_cnt < stall_len) begin
                    stall_cnt++;
                    check("stall_quiet", 32'({spi_clk, spi_mosi}), 32'({1'b0, w2[0]}));
                end else begin
                    w = word_of(first, base, word_idx);
                    pixel_data  = w;
                    pixel_valid = 1'b1;
                    exp_q.push_back(w);
                    word_idx++;
                    last_acc = c;
                end
            end
        end
        pixel_valid = 1'b0;
        if (aborted) begin
            exp_q.delete();
            repeat (20) tick();
            check("abort_no_done", 32'(done_cnt - done0), 0);
            check("abort_idle", 32'({fsm_state, spi_clk, spi_cs_n}), 3'b000_0_1);
        end else begin
            check("frame_end", 32'(done_at), 32'(exp_period));
            check("done_latency", 32'(done_at - last_acc), 66);
            check("busy_fall", 32'({busy, spi_cs_n, spi_clk, spi_mosi}), 4'b0100);
            check("rise_count", 32'(rise_cnt - rise0), NW * 16);
            check("rx_all", 32'(exp_q.size()), 0);
            tick();
            check("done_pulse", 32'(frame_done), 0);
            if (poke) begin
                repeat (100) tick();
                check("start_ignored", 32'({busy, spi_cs_n}), 1);
            end
            check("one_done", 32'(done_cnt - done0), 1);
        end
    endtask

    initial begin
        int rise_mark;
        // reset then idle
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_state",
              32'({spi_clk, spi_mosi, spi_cs_n, pixel_ready, busy, frame_done, fsm_state}), 9'b001000000);
        rise_mark = rise_cnt;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_quiet", 32'({spi_clk, spi_cs_n, busy, pixel_ready}), 4'b0100);
        end
        check("idle_no_edges", 32'(rise_cnt - rise_mark), 0);

        // plain frame, first word F0A5 then incrementing
        run_frame(16'hF0A5, 16'h0000, 0, 1'b0, -1, FRAME_CYCLES);

        // underrun of 50 cycles before word 3
        run_frame(16'h5A3D, 16'h5A3D, 50, 1'b0, -1, FRAME_CYCLES + 50);

        // start pulsed mid-frame is ignored, then a second frame runs normally
        run_frame(16'h1234, 16'hC000, 0, 1'b1, -1, FRAME_CYCLES);
        run_frame(16'hFFFF, 16'h8001, 0, 1'b0, -1, FRAME_CYCLES);

        // reset after 7 bits of word 10, then a fresh frame from word 0
        run_frame(16'hA5A5, 16'h0100, 0, 1'b0, 10 * 16 + 7, FRAME_CYCLES);
        run_frame(16'h0F0F, 16'h0700, 0, 1'b0, -1, FRAME_CYCLES);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hub75_spi_streamer.md
Name: hub75_spi_streamer

Overview:
- SPI master that transmits a frame of 16-bit pixel words to the HUB75 panel controller's SPI pixel-input port.
- It is the transmitting end of that link. The panel controller's SPI slave samples MOSI on the rising edge of spi_clk, has no chip-select, and counts words to place pixels in its framebuffer.
- Sits in the host-side FPGA between a pixel source (framebuffer reader or pattern generator) and the board-to-board SPI wires.
- Pixel format: [15:12] red, [11:8] green, [7:4] blue, [3:0] don't-care, sent MSB first.

Parameters:
- CLK_DIV, 2, spi_clk half-period in clk cycles (must be >= 1).
- WORDS_PER_FRAME, 2048, pixel words per frame (64x32 panel, two half-panels of 1024).
- WORD_BITS, 16, bits per pixel word.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request to send one frame; sampled only in IDLE.
- pixel_data  input  16  next pixel word from the source.
- pixel_valid  input  1  pixel_data is valid.
- pixel_ready  output  1  streamer accepts pixel_data this cycle.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- frame_done  output  1  one-cycle pulse when the last bit of the frame has been clocked.
- spi_clk  output  1  SPI clock, idle low (mode 0).
- spi_mosi  output  1  SPI data, changes only while spi_clk is low.
- spi_cs_n  output  1  frame envelope, active low; the current panel controller ignores it.
- spi_miso  input  1  unused; the panel controller drives 0. Not sampled.

Behaviour:
- Reset values: spi_clk=0, spi_mosi=0, spi_cs_n=1, pixel_ready=0, busy=0, frame_done=0, state=IDLE, word and bit counters=0.
- All outputs are registered except pixel_ready, which is combinational: (state==LOAD).
- States: IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, DONE.
- IDLE:
  - If start=1: go to LOAD, spi_cs_n<=0, busy<=1, word_cnt<=0.
  - Otherwise stay in IDLE.
- LOAD:
  - spi_clk is held 0.
  - If pixel_valid=1: shreg<=pixel_data, spi_mosi<=pixel_data[15], bit_cnt<=WORD_BITS-1, div_cnt<=0, go to SHIFT_LOW.
  - If pixel_valid=0: stay in LOAD indefinitely. Underrun is a legal stall because the slave is purely clock-driven.
- SHIFT_LOW:
  - spi_clk=0. div_cnt counts 0..CLK_DIV-1.
  - On terminal count: spi_clk<=1, div_cnt<=0, go to SHIFT_HIGH.
  - MOSI therefore has CLK_DIV cycles of setup before the rising edge.
- SHIFT_HIGH:
  - spi_clk=1 for CLK_DIV cycles. On terminal count: spi_clk<=0, div_cnt<=0.
  - If bit_cnt!=0: shift shreg left, spi_mosi<=next bit, bit_cnt--, go to SHIFT_LOW.
  - Else if word_cnt==WORDS_PER_FRAME-1: go to DONE.
  - Else: word_cnt++, go to LOAD.
- DONE:
  - spi_cs_n<=1, frame_done<=1 for exactly one cycle, busy<=0, spi_mosi<=0, go to IDLE.
- Timing:
  - Unstalled word period: 1 + 2*CLK_DIV*WORD_BITS clk cycles (65 with defaults).
  - Frame period: WORDS_PER_FRAME * that, plus 2 cycles (start accept and DONE).
- start while busy is ignored; no queueing.
- spi_mosi must never change in the same cycle that spi_clk rises or while spi_clk is high.
- Exactly WORD_BITS rising edges per accepted word. No spi_clk edges in IDLE, LOAD or DONE.
- Reset mid-frame: abort immediately to reset values; no frame_done pulse.
  - The partial frame leaves the slave's word alignment corrupted. System level must reset the panel controller alongside this block.
- Counters: word_cnt width clog2(WORDS_PER_FRAME), bit_cnt width clog2(WORD_BITS), div_cnt width clog2(CLK_DIV)+1. No wrap occurs inside a frame.

Test Plan:
- Reset then idle: hold reset 3 cycles, release, no start -> spi_clk=0, spi_cs_n=1, busy=0, pixel_ready=0 for 100 cycles.
- Single word, WORDS_PER_FRAME=1, CLK_DIV=2: start, pixel_data=16'hF0A5 valid -> a bench SPI slave model sampling on rising edges captures 16'hF0A5 MSB first. frame_done pulses once, 66 cycles after pixel acceptance (65 word + 1 DONE). spi_cs_n low throughout the transfer.
- Full default frame: 2048 incrementing words (0x0000..0x07FF), pixel_valid always 1 -> slave model receives all 2048 in order, exactly 32768 rising edges, one frame_done, busy falls with it.
- Underrun: deassert pixel_valid for 50 cycles before word 3 -> spi_clk stays low, spi_mosi stable for the whole stall. Received data unchanged, and the frame completes 50 cycles later than unstalled.
- start during busy: pulse start mid-frame -> ignored, exactly one frame_done. A start after frame_done begins a second frame.
- Reset mid-word, after 7 bits of word 10 -> next cycle spi_clk=0, spi_cs_n=1, busy=0, no frame_done. A fresh start resends from word 0.
